// File: rtl/fp_issue_pkg.sv
// fp_issue_pkg: shared constants and types for the FP operation issue queue.
// Holds the FP unit opcode encoding, per-op unit latencies, the FSM state
// encoding and the quiet-NaN pattern returned on a watchdog abort.
package fp_issue_pkg;

  // Opcode values driven on the FP unit's n select
  localparam logic [1:0] OP_ADD     = 2'd0;
  localparam logic [1:0] OP_SUB     = 2'd1;
  localparam logic [1:0] OP_MUL     = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  // FP unit latency in cycles from the start edge until done returns high
  localparam int unsigned LAT_ADD = 7;
  localparam int unsigned LAT_SUB = 7;
  localparam int unsigned LAT_MUL = 5;

  // Result reported when the watchdog abandons an operation
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Issue sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Nominal unit latency for an opcode; illegal ops complete at once
  function automatic int unsigned op_latency(input logic [1:0] op);
    case (op)
      OP_ADD:  return LAT_ADD;
      OP_SUB:  return LAT_SUB;
      OP_MUL:  return LAT_MUL;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// fp_req_fifo: synchronous request FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy counter. The head entry is presented combinationally
// and is captured by the consumer's own register on a pop.
module fp_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // Advance write/read pointers on accepted push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + PTR_ONE;
      if (do_rd) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/fp_op_issue_queue.sv
// fp_op_issue_queue: buffers FP add/sub/mul requests, issues them one at a
// time to the multi-cycle FP unit and returns results with their tags in
// request order over a valid/ready response port.
// Optional watchdog abort in WAIT: define FP_OP_ISSUE_QUEUE_TIMEOUT_EN.
module fp_op_issue_queue
  import fp_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [31:0]      fu_dataa,
  output logic [31:0]      fu_datab,
  output logic [1:0]       fu_n,
  output logic             fu_start,
  output logic             fu_clk_en,
  input  logic [31:0]      fu_result,
  input  logic             fu_done
);

  localparam int ENTRY_W = 2 + 32 + 32 + TAG_W;

  // Reject configurations the pointer scheme and 5-bit watchdog cannot hold
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 31) begin : g_param_check
    $error("fp_op_issue_queue: DEPTH must be a power of two in 2..16, TIMEOUT in 1..31");
  end

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [1:0]         head_op;
  logic [31:0]        head_a;
  logic [31:0]        head_b;
  logic [TAG_W-1:0]   head_tag;

  state_e             state_q;
  logic [1:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [TAG_W-1:0]   tag_q;
  logic               fu_start_q;
  logic               fu_clk_en_q;
  logic               wait_first_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               rsp_err_q;

`ifdef FP_OP_ISSUE_QUEUE_TIMEOUT_EN
  localparam logic [4:0] WDOG_LAST = 5'(TIMEOUT - 1);
  logic [4:0]         wdog_q;
`endif

  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign fifo_wdata = {req_op, req_a, req_b, req_tag};
  assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

  // Pop the head when the sequencer is free: from IDLE with no result pending,
  // or from RESP in the same cycle the consumer takes the current result
  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE && !rsp_valid_q) ||
                (state_q == ST_RESP && rsp_ready));

  fp_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (push),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Issue sequencer with operand and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      fu_start_q   <= 1'b0;
      fu_clk_en_q  <= 1'b0;
      wait_first_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
`ifdef FP_OP_ISSUE_QUEUE_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      fu_clk_en_q <= 1'b1;
      fu_start_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pop) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // The unit latches start on this edge; its done flag is only
          // trustworthy from the following edge onwards
          wait_first_q <= 1'b1;
`ifdef FP_OP_ISSUE_QUEUE_TIMEOUT_EN
          wdog_q       <= '0;
`endif
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_first_q <= 1'b0;
          if (!wait_first_q && fu_done) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= fu_result;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= (op_q == OP_ILLEGAL);
            state_q     <= ST_RESP;
          end
`ifdef FP_OP_ISSUE_QUEUE_TIMEOUT_EN
          else if (wdog_q == WDOG_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= QNAN;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wdog_q <= wdog_q + 5'd1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= pop ? ST_ISSUE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Head of queue moves into the operand registers and starts the unit
      if (pop) begin
        op_q       <= head_op;
        a_q        <= head_a;
        b_q        <= head_b;
        tag_q      <= head_tag;
        fu_start_q <= 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign fu_dataa  = a_q;
  assign fu_datab  = b_q;
  assign fu_n      = op_q;
  assign fu_start  = fu_start_q;
  assign fu_clk_en = fu_clk_en_q;

endmodule

// File: tb/tb_fp_op_issue_queue.sv
// tb_fp_op_issue_queue: directed scoreboard bench for fp_op_issue_queue.
// A behavioural FP unit stub answers from a small table of hand-computed
// IEEE-754 results. Watchdog test runs when FP_OP_ISSUE_QUEUE_TIMEOUT_EN is set.
module tb_fp_op_issue_queue;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [31:0]      fu_dataa;
  logic [31:0]      fu_datab;
  logic [1:0]       fu_n;
  logic             fu_start;
  logic             fu_clk_en;
  logic [31:0]      fu_result;
  logic             fu_done;

  fp_op_issue_queue #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .fu_dataa  (fu_dataa),
    .fu_datab  (fu_datab),
    .fu_n      (fu_n),
    .fu_start  (fu_start),
    .fu_clk_en (fu_clk_en),
    .fu_result (fu_result),
    .fu_done   (fu_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // FP unit stub: hand-computed results, latency 7/7/5, illegal op done at once
  function automatic logic [31:0] stub_table(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    if (op == 2'd3) return 32'h1234_5678;
    case ({op, a, b})
      {2'd0, 32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1+2=3
      {2'd2, 32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000; // 2*3=6
      {2'd1, 32'h40A0_0000, 32'h3F80_0000}: return 32'h4080_0000; // 5-1=4
      {2'd0, 32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000; // 1+1=2
      {2'd2, 32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000; // 2*2=4
      {2'd1, 32'h4040_0000, 32'h3F80_0000}: return 32'h4000_0000; // 3-1=2
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  int          stub_cnt  = 0;
  logic [31:0] stub_res  = '0;
  logic        stub_hang = 1'b0;
  logic        hang_mode = 1'b0;

  always @(posedge clk) begin
    if (fu_start && fu_clk_en) begin
      stub_res  <= stub_table(fu_n, fu_dataa, fu_datab);
      stub_cnt  <= (fu_n == 2'd2) ? 5 : (fu_n == 2'd3) ? 0 : 7;
      stub_hang <= hang_mode;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign fu_done   = (stub_cnt == 0) && !stub_hang;
  assign fu_result = stub_res;

  // Monitor: scoreboard pop on handshake, hold stability, start-pulse rules
  initial begin : monitor
    exp_t             e;
    logic             hold_prev  = 1'b0;
    logic [31:0]      hold_data  = '0;
    logic [TAG_W-1:0] hold_tag   = '0;
    logic             hold_err   = 1'b0;
    logic             start_prev = 1'b0;
    logic             outstanding = 1'b0;
    logic             valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        hold_prev   = 1'b0;
        start_prev  = 1'b0;
        outstanding = 1'b0;
        valid_prev  = 1'b0;
      end else begin
        if (hold_prev) begin
          check("rsp_hold_valid", 64'(rsp_valid), 64'(1'b1));
          check("rsp_hold_payload", 64'({rsp_data, rsp_tag, rsp_err}),
                64'({hold_data, hold_tag, hold_err}));
        end
        if (fu_start) begin
          check("start_single_cycle", 64'(start_prev), 64'(1'b0));
          check("start_no_overlap", 64'(outstanding), 64'(1'b0));
          outstanding = 1'b1;
        end
        start_prev = fu_start;
        if (rsp_valid && !valid_prev) outstanding = 1'b0;
        valid_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual tag=%0d data=%h required=no response",
                     rsp_tag, rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data_tag_err", 64'({rsp_data, rsp_tag, rsp_err}),
                  64'({e.data, e.tag, e.err}));
            $display("rsp tag=%0d data=%h err=%0d expected tag=%0d data=%h err=%0d",
                     rsp_tag, rsp_data, rsp_err, e.tag, e.data, e.err);
          end
        end
        hold_prev = rsp_valid && !rsp_ready;
        hold_data = rsp_data;
        hold_tag  = rsp_tag;
        hold_err  = rsp_err;
      end
    end
  end

  // Present a request at a negedge and hold it until accepted; record the expectation
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                      input logic exp_err, output int unsigned acc_cyc);
    int guard = 0;
    exp_t e;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    acc_cyc = 0;
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout actual=req_ready low required=accept tag %0d", tag);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    e.data = exp_data; e.tag = tag; e.err = exp_err;
    exp_q.push_back(e);
    n_acc++;
    $display("req op=%0d a=%h b=%h tag=%0d accepted cyc=%0d", op, a, b, tag, acc_cyc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; returns the cycle index at which it is seen
  task automatic wait_rsp_valid(input string name, output int unsigned at_cyc);
    int guard = 0;
    while (!rsp_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    at_cyc = cyc;
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=rsp_valid low required=rsp_valid high", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || rsp_valid) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready_valid_start_en"}, 64'({req_ready, rsp_valid, fu_start, fu_clk_en}),
          64'(4'b1000));
    check({name, "_rsp_payload"}, 64'({rsp_data, rsp_tag, rsp_err}), 64'd0);
    check({name, "_fu_operands"}, {fu_dataa, fu_datab}, 64'd0);
    check({name, "_fu_n"}, 64'(fu_n), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int unsigned acc;
    int unsigned at;
    int unsigned d0;
    int          base;
    int          g;
    int          spurious;

    // Reset state
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("clk_en_before_first_edge", 64'(fu_clk_en), 64'(1'b0));
    @(negedge clk);
    check("clk_en_after_first_edge", 64'(fu_clk_en), 64'(1'b1));
    check("req_ready_after_reset", 64'(req_ready), 64'(1'b1));

    // Single add: 1.0 + 2.0 = 3.0, tag 5, valid 10 cycles after acceptance
    rsp_ready = 1'b1;
    send(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1'b0, acc);
    wait_rsp_valid("single_add", at);
    check("single_add_latency", 64'(at - acc), 64'd10);
    wait_drain("drain_single");

    // Back-to-back mul/sub/add
    send(2'd2, 32'h4000_0000, 32'h4040_0000, 4'd1, 32'h40C0_0000, 1'b0, acc);
    send(2'd1, 32'h40A0_0000, 32'h3F80_0000, 4'd2, 32'h4080_0000, 1'b0, d0);
    send(2'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd3, 32'h4000_0000, 1'b0, d0);
    wait_drain("drain_b2b");

    // Illegal op: error response after the WAIT ignore cycle, queue continues
    send(2'd3, 32'h3F80_0000, 32'h3F80_0000, 4'd9, 32'h1234_5678, 1'b1, acc);
    send(2'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd3, 32'h4000_0000, 1'b0, d0);
    wait_rsp_valid("illegal", at);
    check("illegal_latency", 64'(at - acc), 64'd4);
    wait_drain("drain_illegal");

    // Full FIFO with consumer stalled: DEPTH+2 requests
    rsp_ready = 1'b0;
    base = n_acc;
    fork
      begin
        send(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd10, 32'h4040_0000, 1'b0, d0);
        send(2'd2, 32'h4000_0000, 32'h4040_0000, 4'd11, 32'h40C0_0000, 1'b0, d0);
        send(2'd1, 32'h40A0_0000, 32'h3F80_0000, 4'd12, 32'h4080_0000, 1'b0, d0);
        send(2'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd13, 32'h4000_0000, 1'b0, d0);
        send(2'd2, 32'h4000_0000, 32'h4000_0000, 4'd14, 32'h4080_0000, 1'b0, d0);
        send(2'd1, 32'h4040_0000, 32'h3F80_0000, 4'd15, 32'h4000_0000, 1'b0, d0);
      end
      begin
        g = 0;
        while (n_acc < base + 5 && g < 100) begin
          @(negedge clk);
          g++;
        end
        repeat (2) @(negedge clk);
        check("req_ready_full", 64'(req_ready), 64'(1'b0));
        wait_rsp_valid("full_first", at);
        check("full_first_tag", 64'(rsp_tag), 64'd10);
        repeat (6) @(negedge clk);
        check("req_ready_still_full", 64'(req_ready), 64'(1'b0));
        check("accepted_while_stalled", 64'(n_acc - base), 64'd5);
        rsp_ready = 1'b1;
      end
    join
    wait_drain("drain_full");

    // Asynchronous reset during WAIT: in-flight op dropped, no response
    send(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd7, 32'h4040_0000, 1'b0, acc);
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("req_ready_after_release", 64'(req_ready), 64'(1'b1));
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    check("no_spurious_rsp_after_reset", 64'(spurious), 64'd0);
    check("clk_en_after_release", 64'(fu_clk_en), 64'(1'b1));

`ifdef FP_OP_ISSUE_QUEUE_TIMEOUT_EN
    // Watchdog: unit never completes, abort after TIMEOUT WAIT cycles
    hang_mode = 1'b1;
    send(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd6, 32'h7FC0_0000, 1'b1, acc);
    wait_rsp_valid("timeout", at);
    check("timeout_latency", 64'(at - acc), 64'd17);
    hang_mode = 1'b0;
    wait_drain("drain_timeout");
    send(2'd0, 32'h3F80_0000, 32'h3F80_0000, 4'd8, 32'h4000_0000, 1'b0, d0);
    wait_drain("drain_after_timeout");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_op_issue_queue.md
Name: fp_op_issue_queue

Overview:
- Upstream feeder for the floating-point custom-instruction unit (add/sub/mul, opcode on a 2-bit select).
- Buffers operation requests from a valid/ready producer in a small FIFO.
- Issues one operation at a time to the FP unit and waits for its done.
- Returns each result with its tag through a valid/ready result port, in request order.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16.
- TAG_W, 4, width of the caller tag carried with each request.
- TIMEOUT, 15, cycles allowed in WAIT before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; high when not full.
- req_op  in  2  0=add, 1=sub, 2=mul, 3=illegal.
- req_a  in  32  operand A, IEEE-754 single.
- req_b  in  32  operand B.
- req_tag  in  TAG_W  caller tag.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  32  FP result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_err  out  1  illegal op, or timeout abort.
- fu_dataa  out  32  to FP unit dataa.
- fu_datab  out  32  to FP unit datab.
- fu_n  out  2  to FP unit opcode.
- fu_start  out  1  one-cycle start pulse.
- fu_clk_en  out  1  FP unit clock enable.
- fu_result  in  32  FP unit result.
- fu_done  in  1  FP unit done; level, high while idle.

Behaviour:
- Reset: FIFO empty, state IDLE. req_ready=1, rsp_valid=0, fu_start=0, fu_clk_en=0. rsp_data, rsp_tag, rsp_err, fu_dataa, fu_datab, fu_n all 0.
- fu_clk_en: registered; 1 from the first clock after reset deassertion.
- Enqueue: on req_valid&&req_ready, write {op,a,b,tag} at wptr. Pointers are DEPTH-wrap with an extra bit for full/empty; count is 0..DEPTH.
- Simultaneous enqueue and dequeue when full: not allowed; req_ready is based on current full only.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when the FIFO is non-empty and rsp_valid=0. Pop the head into the operand registers, which drive fu_dataa, fu_datab, fu_n.
- ISSUE: fu_start=1 for exactly one cycle -> WAIT. An illegal op (3) is still issued; the FP unit reports done immediately.
- WAIT, first cycle after ISSUE: ignore fu_done (the unit's counter updates on that edge).
- WAIT, later cycles: when fu_done=1, capture rsp_data=fu_result, rsp_tag, and rsp_err=(op==3). Set rsp_valid=1 and go to RESP.
- RESP: hold all rsp_* stable while rsp_valid&&!rsp_ready. When rsp_ready=1, clear rsp_valid.
  - Go to ISSUE if the FIFO is non-empty, popping in the same cycle.
  - Otherwise go to IDLE.
- Latency, with empty FIFO and rsp_ready=1: request accepted at cycle 0.
  - Pop at cycle 1 (IDLE->ISSUE), start at cycle 2.
  - rsp_valid at cycle 2+L+1, where L is the FP unit latency (add/sub 7 -> cycle 10, mul 5 -> cycle 8).
- Only one op is in flight at a time; results are returned in request order.
- Asynchronous reset mid-operation: all state is discarded; the in-flight op is lost with no response. The FP unit pipeline is ignored afterwards because fu_start is low.

Optional Feature:
- Macro: FP_OP_ISSUE_QUEUE_TIMEOUT_EN.
- With it: a 5-bit watchdog counts cycles in WAIT. When it reaches TIMEOUT without fu_done:
  - rsp_valid=1, rsp_err=1, rsp_data=32'h7FC00000 (quiet NaN), rsp_tag=in-flight tag.
  - Enter RESP; the counter clears on every entry to WAIT.
- Without it: WAIT persists indefinitely; no counter is synthesized.

Decomposition:
- Shared package fp_issue_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_ILLEGAL=3.
  - latency constants 7/7/5.
  - FSM state encoding.
  - QNAN constant.
- One natural sub-module: fp_req_fifo.
  - Parameterised DEPTH/width synchronous FIFO with full/empty.
  - Same clk/reset_n.
- FSM and response register stay in the top.

Test Plan:
- Single add: op0, a=3F800000 (1.0), b=40000000 (2.0), tag 5 -> one fu_start, rsp at cycle 10, rsp_data=40400000, tag 5, err 0.
- Back-to-back: enqueue mul(2.0,3.0) tag1, sub(5.0,1.0) tag2, add(1.0,1.0) tag3 with rsp_ready=1.
  - Expect responses 40C00000/1, 40800000/2, 40000000/3 in order.
  - Never two fu_start pulses without an intervening done.
- Full FIFO: hold rsp_ready=0 and push DEPTH+2 requests.
  - req_ready drops after the FIFO holds 4 (plus 1 in flight).
  - rsp_* stay stable; releasing rsp_ready drains all in order.
- Illegal op 3, tag 9 -> rsp_err=1, tag 9, one cycle after the WAIT ignore cycle; the queue continues with the next request.
- Reset: assert reset_n=0 during WAIT -> all outputs at reset values immediately (async); after release, req_ready=1 and no spurious rsp_valid.
- With FP_OP_ISSUE_QUEUE_TIMEOUT_EN: stub fu_done held 0 after start -> rsp_valid after TIMEOUT=15 WAIT cycles, rsp_err=1, rsp_data=7FC00000.
